// File: rtl/mips_alu_arbiter.sv
// Round-robin arbiter sharing one combinational MIPS ALU between two requesters.
// One transaction is outstanding at a time: grant, hold ALU inputs, capture, respond.
module mips_alu_arbiter #(
  parameter int EXEC_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_0,
  input  logic        req_valid_1,
  output logic        req_ready_0,
  output logic        req_ready_1,
  input  logic [3:0]  req_op_0,
  input  logic [3:0]  req_op_1,
  input  logic [31:0] req_a_0,
  input  logic [31:0] req_a_1,
  input  logic [31:0] req_b_0,
  input  logic [31:0] req_b_1,
  input  logic [4:0]  req_shamt_0,
  input  logic [4:0]  req_shamt_1,
  output logic        rsp_valid_0,
  output logic        rsp_valid_1,
  input  logic        rsp_ready_0,
  input  logic        rsp_ready_1,
  output logic [31:0] rsp_result_0,
  output logic [31:0] rsp_result_1,
  output logic        rsp_zero_0,
  output logic        rsp_zero_1,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_first_data,
  output logic [31:0] alu_second_data,
  output logic [4:0]  alu_shamt,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        owner_q, owner_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  alu_op_q, alu_op_d;
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  logic [4:0]  alu_shamt_q, alu_shamt_d;
  logic [1:0]  rsp_valid_q, rsp_valid_d;
  logic [1:0]  rsp_zero_q, rsp_zero_d;
  logic [31:0] rsp_result_0_q, rsp_result_0_d;
  logic [31:0] rsp_result_1_q, rsp_result_1_d;
  logic        grant_0, grant_1;

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    owner_d        = owner_q;
    cnt_d          = cnt_q;
    alu_op_d       = alu_op_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    alu_shamt_d    = alu_shamt_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_zero_d     = rsp_zero_q;
    rsp_result_0_d = rsp_result_0_q;
    rsp_result_1_d = rsp_result_1_q;
    grant_0        = 1'b0;
    grant_1        = 1'b0;
    case (state_q)
      IDLE: begin
        // On a tie the port that did not win last time is granted.
        grant_0 = req_valid_0 & (~req_valid_1 | last_grant_q);
        grant_1 = req_valid_1 & (~req_valid_0 | ~last_grant_q);
        if (grant_0 | grant_1) begin
          alu_op_d     = grant_1 ? req_op_1    : req_op_0;
          alu_a_d      = grant_1 ? req_a_1     : req_a_0;
          alu_b_d      = grant_1 ? req_b_1     : req_b_0;
          alu_shamt_d  = grant_1 ? req_shamt_1 : req_shamt_0;
          owner_d      = grant_1;
          last_grant_d = grant_1;
          cnt_d        = CNT_INIT;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (owner_q) rsp_result_1_d = alu_result;
          else         rsp_result_0_d = alu_result;
          rsp_zero_d[owner_q]  = alu_zero;
          rsp_valid_d[owner_q] = 1'b1;
          state_d              = RESP;
        end
      end
      RESP: begin
        if (owner_q ? rsp_ready_1 : rsp_ready_0) begin
          rsp_valid_d[owner_q] = 1'b0;
          state_d              = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      last_grant_q   <= 1'b1;
      owner_q        <= 1'b0;
      cnt_q          <= 4'd0;
      alu_op_q       <= 4'd0;
      alu_a_q        <= 32'd0;
      alu_b_q        <= 32'd0;
      alu_shamt_q    <= 5'd0;
      rsp_valid_q    <= 2'b00;
      rsp_zero_q     <= 2'b00;
      rsp_result_0_q <= 32'd0;
      rsp_result_1_q <= 32'd0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      owner_q        <= owner_d;
      cnt_q          <= cnt_d;
      alu_op_q       <= alu_op_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      alu_shamt_q    <= alu_shamt_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_zero_q     <= rsp_zero_d;
      rsp_result_0_q <= rsp_result_0_d;
      rsp_result_1_q <= rsp_result_1_d;
    end
  end

  assign req_ready_0     = (state_q == IDLE) & grant_0;
  assign req_ready_1     = (state_q == IDLE) & grant_1;
  assign rsp_valid_0     = rsp_valid_q[0];
  assign rsp_valid_1     = rsp_valid_q[1];
  assign rsp_zero_0      = rsp_zero_q[0];
  assign rsp_zero_1      = rsp_zero_q[1];
  assign rsp_result_0    = rsp_result_0_q;
  assign rsp_result_1    = rsp_result_1_q;
  assign alu_op          = alu_op_q;
  assign alu_first_data  = alu_a_q;
  assign alu_second_data = alu_b_q;
  assign alu_shamt       = alu_shamt_q;
  assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_mips_alu_arbiter.sv
// Bench for mips_alu_arbiter: directed scenarios plus randomized traffic against
// a transaction-level model (one instance with 1 settle cycle, one with 3).
module tb_mips_alu_arbiter;

  localparam int EC = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        reset;
  logic        v0, v1, r0, r1;
  logic [3:0]  op0, op1;
  logic [31:0] a0, a1, b0, b1;
  logic [4:0]  s0, s1;
  logic        rdy0, rdy1, rv0, rv1, z0, z1, busy;
  logic [31:0] res0, res1;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [4:0]  alu_shamt;
  logic        alu_zero;

  assign alu_result = alu_a + alu_b;
  assign alu_zero   = (alu_result == 32'd0);

  mips_alu_arbiter #(.EXEC_CYCLES(EC)) dut (
    .clk(clk), .reset(reset),
    .req_valid_0(v0), .req_valid_1(v1), .req_ready_0(rdy0), .req_ready_1(rdy1),
    .req_op_0(op0), .req_op_1(op1), .req_a_0(a0), .req_a_1(a1),
    .req_b_0(b0), .req_b_1(b1), .req_shamt_0(s0), .req_shamt_1(s1),
    .rsp_valid_0(rv0), .rsp_valid_1(rv1), .rsp_ready_0(r0), .rsp_ready_1(r1),
    .rsp_result_0(res0), .rsp_result_1(res1), .rsp_zero_0(z0), .rsp_zero_1(z1),
    .alu_op(alu_op), .alu_first_data(alu_a), .alu_second_data(alu_b),
    .alu_shamt(alu_shamt), .alu_result(alu_result), .alu_zero(alu_zero),
    .busy(busy)
  );

  logic [1:0]  v3, r3;
  logic [3:0]  op3;
  logic [31:0] a3, b3;
  logic [4:0]  s3;
  logic        rdy3_0, rdy3_1, rv3_0, rv3_1, z3_0, z3_1, busy3, az3;
  logic [31:0] res3_0, res3_1, aa3, ab3, ar3;
  logic [3:0]  aop3;
  logic [4:0]  as3;

  assign ar3 = aa3 + ab3;
  assign az3 = (ar3 == 32'd0);

  mips_alu_arbiter #(.EXEC_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset),
    .req_valid_0(v3[0]), .req_valid_1(v3[1]), .req_ready_0(rdy3_0), .req_ready_1(rdy3_1),
    .req_op_0(op3), .req_op_1(op3), .req_a_0(a3), .req_a_1(a3),
    .req_b_0(b3), .req_b_1(b3), .req_shamt_0(s3), .req_shamt_1(s3),
    .rsp_valid_0(rv3_0), .rsp_valid_1(rv3_1), .rsp_ready_0(r3[0]), .rsp_ready_1(r3[1]),
    .rsp_result_0(res3_0), .rsp_result_1(res3_1), .rsp_zero_0(z3_0), .rsp_zero_1(z3_1),
    .alu_op(aop3), .alu_first_data(aa3), .alu_second_data(ab3),
    .alu_shamt(as3), .alu_result(ar3), .alu_zero(az3),
    .busy(busy3)
  );

  int checks = 0;
  int failures = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    v0 = 0; v1 = 0; r0 = 0; r1 = 0;
    op0 = 0; op1 = 0; a0 = 0; a1 = 0; b0 = 0; b1 = 0; s0 = 0; s1 = 0;
    v3 = 0; r3 = 0; op3 = 0; a3 = 0; b3 = 0; s3 = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    tick();
    reset = 0;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    r0 = 1; r1 = 1;
    reset = 1;
    tick();
    reset = 0;
    #1;
    checks++;
    if ({busy, rv0, rv1, z0, z1, rdy0, rdy1} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl got busy=%0b rv=%0b%0b z=%0b%0b rdy=%0b%0b exp all 0", busy, rv0, rv1, z0, z1, rdy0, rdy1);
    end
    checks++;
    if ({res0, res1, alu_op, alu_a, alu_b, alu_shamt} !== '0) begin
      failures++;
      $display("FAIL reset_data got res0=%h res1=%h op=%h a=%h b=%h sh=%h exp 0", res0, res1, alu_op, alu_a, alu_b, alu_shamt);
    end
    tick();
    checks++;
    if ({busy, rv0, rv1} !== 3'b0) begin
      failures++;
      $display("FAIL idle_rsp_ready got busy=%0b rv=%0b%0b exp 000", busy, rv0, rv1);
    end
    v0 = 1; v1 = 1;
    #1;
    checks++;
    if ({rdy0, rdy1} !== 2'b10) begin
      failures++;
      $display("FAIL first_tie got rdy=%0b%0b exp 10", rdy0, rdy1);
    end
    clear_inputs();
    #1;
  endtask

  task automatic test_single();
    do_reset();
    v0 = 1; op0 = 4'b0010; a0 = 5; b0 = 7; s0 = 0; r0 = 1;
    #1;
    checks++;
    if ({rdy0, rdy1} !== 2'b10) begin
      failures++;
      $display("FAIL single_ready got rdy=%0b%0b exp 10", rdy0, rdy1);
    end
    tick();
    v0 = 0; a0 = 32'hDEAD;
    #1;
    checks++;
    if ({alu_op, alu_a, alu_b, busy, rv0, rdy0} !== {4'b0010, 32'd5, 32'd7, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL single_drive got op=%h a=%0d b=%0d busy=%0b rv0=%0b rdy0=%0b exp op=2 a=5 b=7 busy=1 rv0=0 rdy0=0",
               alu_op, alu_a, alu_b, busy, rv0, rdy0);
    end
    tick();
    checks++;
    if ({rv0, rv1, res0, z0} !== {1'b1, 1'b0, 32'd12, 1'b0}) begin
      failures++;
      $display("FAIL single_rsp got rv=%0b%0b res=%0d z=%0b exp rv=10 res=12 z=0", rv0, rv1, res0, z0);
    end
    tick();
    checks++;
    if ({busy, rv0, res0} !== {1'b0, 1'b0, 32'd12}) begin
      failures++;
      $display("FAIL single_idle got busy=%0b rv0=%0b res=%0d exp busy=0 rv0=0 res=12", busy, rv0, res0);
    end
  endtask

  task automatic test_round_robin();
    int last_cyc;
    int n;
    int g;
    do_reset();
    v0 = 1; v1 = 1; op0 = 4'b0010; op1 = 4'b0010;
    a0 = 1; b0 = 1; a1 = 2; b1 = 2; r0 = 1; r1 = 1;
    #1;
    last_cyc = 0;
    for (int k = 0; k < 6; k++) begin
      n = 0;
      while (!(rdy0 | rdy1) && n < 20) begin tick(); n++; end
      checks++;
      if (n >= 20) begin
        failures++;
        $display("FAIL rr_grant_timeout k=%0d got no grant exp grant within 20 cycles", k);
      end
      checks++;
      if ({rdy0, rdy1} !== ((k % 2 == 1) ? 2'b01 : 2'b10)) begin
        failures++;
        $display("FAIL rr_order k=%0d got rdy=%0b%0b exp port %0d", k, rdy0, rdy1, k % 2);
      end
      if (k > 0) begin
        checks++;
        if (cyc - last_cyc != EC + 2) begin
          failures++;
          $display("FAIL rr_interval k=%0d got %0d exp %0d", k, cyc - last_cyc, EC + 2);
        end
      end
      last_cyc = cyc;
      g = rdy1 ? 1 : 0;
      tick();
      n = 0;
      while (!(g == 1 ? rv1 : rv0) && n < 20) begin tick(); n++; end
      checks++;
      if ((g == 1 ? res1 : res0) !== (g == 1 ? 32'd4 : 32'd2) || n >= 20) begin
        failures++;
        $display("FAIL rr_result k=%0d port=%0d got %0d exp %0d", k, g, (g == 1 ? res1 : res0), (g == 1 ? 4 : 2));
      end
      tick();
    end
    clear_inputs();
    #1;
  endtask

  task automatic test_hold();
    do_reset();
    v1 = 1; op1 = 4'b0010; a1 = 32'h80000000; b1 = 32'h80000000; r1 = 0;
    #1;
    checks++;
    if ({rdy0, rdy1} !== 2'b01) begin
      failures++;
      $display("FAIL hold_grant got rdy=%0b%0b exp 01", rdy0, rdy1);
    end
    tick();
    v1 = 0;
    tick();
    v0 = 1; a0 = 9; b0 = 9;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({rv1, res1, z1, rdy0, rv0} !== {1'b1, 32'd0, 1'b1, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL hold_stable i=%0d got rv1=%0b res1=%h z1=%0b rdy0=%0b rv0=%0b exp rv1=1 res1=0 z1=1 rdy0=0 rv0=0",
                 i, rv1, res1, z1, rdy0, rv0);
      end
      tick();
    end
    r1 = 1;
    #1;
    checks++;
    if (rdy0 !== 1'b0) begin
      failures++;
      $display("FAIL hold_no_accept got rdy0=%0b exp 0", rdy0);
    end
    tick();
    checks++;
    if ({rv1, rdy0, busy} !== 3'b010) begin
      failures++;
      $display("FAIL hold_release got rv1=%0b rdy0=%0b busy=%0b exp 0 1 0", rv1, rdy0, busy);
    end
    clear_inputs();
    #1;
  endtask

  task automatic test_exec3();
    do_reset();
    v3 = 2'b01; a3 = 32'h7FFFFFFF; b3 = 32'd1; op3 = 4'b0110; s3 = 5'd3; r3 = 2'b11;
    #1;
    checks++;
    if ({rdy3_0, rdy3_1} !== 2'b10) begin
      failures++;
      $display("FAIL ex3_grant got rdy=%0b%0b exp 10", rdy3_0, rdy3_1);
    end
    tick();
    v3 = 0;
    for (int i = 0; i < 3; i++) begin
      a3 = $urandom; b3 = $urandom; op3 = 4'($urandom); s3 = 5'($urandom);
      #1;
      checks++;
      if ({aop3, aa3, ab3, as3, busy3, rv3_0} !== {4'b0110, 32'h7FFFFFFF, 32'd1, 5'd3, 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL ex3_stable i=%0d got op=%h a=%h b=%h sh=%0d busy=%0b rv=%0b exp op=6 a=7fffffff b=1 sh=3 busy=1 rv=0",
                 i, aop3, aa3, ab3, as3, busy3, rv3_0);
      end
      tick();
    end
    checks++;
    if ({rv3_0, res3_0, z3_0} !== {1'b1, 32'h80000000, 1'b0}) begin
      failures++;
      $display("FAIL ex3_rsp got rv=%0b res=%h z=%0b exp rv=1 res=80000000 z=0", rv3_0, res3_0, z3_0);
    end
    tick();
    clear_inputs();
    #1;
  endtask

  task automatic test_reset_mid();
    do_reset();
    v0 = 1; op0 = 4'b1001; a0 = 3; b0 = 4; r0 = 1; r1 = 1;
    #1;
    tick();
    v0 = 0;
    #1;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL rmid_exec got busy=%0b exp 1", busy);
    end
    reset = 1;
    tick();
    reset = 0;
    #1;
    checks++;
    if ({busy, rv0, rv1, alu_op} !== 7'b0) begin
      failures++;
      $display("FAIL rmid_state got busy=%0b rv=%0b%0b op=%h exp 0 00 0", busy, rv0, rv1, alu_op);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({busy, rv0, rv1} !== 3'b0) begin
        failures++;
        $display("FAIL rmid_noresp i=%0d got busy=%0b rv=%0b%0b exp 000", i, busy, rv0, rv1);
      end
    end
    clear_inputs();
    #1;
  endtask

  task automatic test_unused_op();
    logic [3:0] codes [2];
    logic [31:0] sum;
    codes[0] = 4'b1101;
    codes[1] = 4'b0011;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      v0 = 1; op0 = codes[i]; a0 = $urandom; b0 = $urandom; s0 = 5'($urandom); r0 = 1;
      sum = a0 + b0;
      #1;
      tick();
      v0 = 0;
      #1;
      checks++;
      if ({alu_op, alu_shamt} !== {codes[i], s0}) begin
        failures++;
        $display("FAIL unused_op got op=%b sh=%0d exp op=%b sh=%0d", alu_op, alu_shamt, codes[i], s0);
      end
      tick();
      checks++;
      if ({rv0, res0, z0} !== {1'b1, sum, (sum == 32'd0)}) begin
        failures++;
        $display("FAIL unused_rsp got rv=%0b res=%h z=%0b exp rv=1 res=%h", rv0, res0, z0, sum);
      end
      tick();
    end
    clear_inputs();
    #1;
  endtask

  // Transaction-level model: one job in flight, response due EC cycles after acceptance.
  task automatic test_random();
    bit          m_busy, m_owner, m_last;
    int          m_wait;
    bit   [1:0]  m_rv, m_z;
    logic [31:0] m_res [2];
    logic [31:0] m_pend;
    logic [3:0]  m_op;
    logic [31:0] m_a, m_b;
    logic [4:0]  m_sh;
    bit          eg0, eg1;
    do_reset();
    m_busy = 0; m_owner = 0; m_last = 1; m_wait = 0; m_rv = 0; m_z = 0;
    m_res[0] = 0; m_res[1] = 0; m_pend = 0; m_op = 0; m_a = 0; m_b = 0; m_sh = 0;
    for (int c = 0; c < 400; c++) begin
      v0 = ($urandom_range(0, 2) != 0); v1 = ($urandom_range(0, 2) != 0);
      r0 = ($urandom_range(0, 2) != 0); r1 = ($urandom_range(0, 2) != 0);
      op0 = 4'($urandom); op1 = 4'($urandom); s0 = 5'($urandom); s1 = 5'($urandom);
      a0 = $urandom; a1 = $urandom;
      b0 = ($urandom_range(0, 3) == 0) ? 32'(0 - a0) : $urandom;
      b1 = ($urandom_range(0, 3) == 0) ? 32'(0 - a1) : $urandom;
      #1;
      eg0 = !m_busy && v0 && (!v1 || m_last);
      eg1 = !m_busy && v1 && (!v0 || !m_last);
      checks++;
      if ({rdy0, rdy1, busy, rv0, rv1} !== {eg0, eg1, m_busy, m_rv[0], m_rv[1]}) begin
        failures++;
        $display("FAIL rand_ctrl c=%0d got rdy=%0b%0b busy=%0b rv=%0b%0b exp rdy=%0b%0b busy=%0b rv=%0b%0b",
                 c, rdy0, rdy1, busy, rv0, rv1, eg0, eg1, m_busy, m_rv[0], m_rv[1]);
      end
      checks++;
      if ({res0, z0, res1, z1} !== {m_res[0], m_z[0], m_res[1], m_z[1]}) begin
        failures++;
        $display("FAIL rand_rsp c=%0d got %h/%0b %h/%0b exp %h/%0b %h/%0b",
                 c, res0, z0, res1, z1, m_res[0], m_z[0], m_res[1], m_z[1]);
      end
      checks++;
      if ({alu_op, alu_a, alu_b, alu_shamt} !== {m_op, m_a, m_b, m_sh}) begin
        failures++;
        $display("FAIL rand_alu c=%0d got %h %h %h %h exp %h %h %h %h",
                 c, alu_op, alu_a, alu_b, alu_shamt, m_op, m_a, m_b, m_sh);
      end
      if (eg0 || eg1) begin
        m_busy = 1; m_owner = eg1; m_last = eg1; m_wait = EC;
        m_op = eg1 ? op1 : op0; m_a = eg1 ? a1 : a0;
        m_b = eg1 ? b1 : b0; m_sh = eg1 ? s1 : s0;
        m_pend = m_a + m_b;
      end else if (m_busy && m_wait != 0) begin
        m_wait--;
        if (m_wait == 0) begin
          m_rv[m_owner] = 1; m_res[m_owner] = m_pend; m_z[m_owner] = (m_pend == 32'd0);
        end
      end else if (m_busy && (m_owner ? r1 : r0)) begin
        m_rv[m_owner] = 0; m_busy = 0;
      end
      tick();
    end
    clear_inputs();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish before 200000");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_hold();
    test_exec3();
    test_reset_mid();
    test_unused_op();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_alu_arbiter.md
Name: mips_alu_arbiter

Overview:
- Shares one combinational mips_alu between two requesters, e.g. the integer-issue path (port 0) and the branch/address-compute path (port 1).
- Grants requests round-robin and drives the ALU's alu_op, first_data, second_data and shamt from registers.
- Waits a programmable number of settle cycles, captures result and zero, and returns them on the granted port's response channel with a valid/ready handshake.

Parameters:
EXEC_CYCLES, 1, number of cycles the ALU inputs are held stable before result/zero are captured; legal range 1..15.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
req_valid_0 / req_valid_1  input  1  requester i has an operation pending.
req_ready_0 / req_ready_1  output  1  operation on port i accepted this cycle.
req_op_0 / req_op_1  input  4  alu_op code for port i, passed through undecoded.
req_a_0 / req_a_1  input  32  first operand, R[s].
req_b_0 / req_b_1  input  32  second operand, R[t] or sign-extended immediate.
req_shamt_0 / req_shamt_1  input  5  shift amount.
rsp_valid_0 / rsp_valid_1  output  1  response for port i available.
rsp_ready_0 / rsp_ready_1  input  1  port i consumes its response.
rsp_result_0 / rsp_result_1  output  32  captured ALU result.
rsp_zero_0 / rsp_zero_1  output  1  captured ALU zero flag.
alu_op  output  4  registered drive to the shared ALU.
alu_first_data  output  32  registered drive to the ALU.
alu_second_data  output  32  registered drive to the ALU.
alu_shamt  output  5  registered drive to the ALU.
alu_result  input  32  ALU result.
alu_zero  input  1  ALU zero flag.
busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset values (synchronous, any state):
  - state=IDLE, last_grant=1 (so port 0 wins the first tie).
  - All alu_* outputs = 0.
  - rsp_valid_* = 0, rsp_result_* = 0, rsp_zero_* = 0.
  - Settle counter = 0.
  - Reset mid-transaction drops the transaction; no response is ever delivered for it.
- States: IDLE, EXEC, RESP.
- Grant logic, IDLE only, combinational:
  - Only port i valid -> grant i.
  - Both valid -> grant the port != last_grant.
  - req_ready_i = (state==IDLE) & grant_i.
  - req_ready_* are low in EXEC and RESP.
  - At most one req_ready is high in any cycle.
- IDLE -> EXEC on a handshake (req_valid_i & req_ready_i):
  - Register req_op/a/b/shamt of port i into the alu_* outputs.
  - Record owner=i and set last_grant=i.
  - Load counter=EXEC_CYCLES-1.
- EXEC:
  - alu_* outputs held stable.
  - Counter != 0 -> decrement.
  - Counter == 0 -> at that edge, capture alu_result/alu_zero into rsp_result_owner/rsp_zero_owner, set rsp_valid_owner=1, go RESP.
- RESP:
  - rsp_valid_owner held high; result and zero held stable.
  - On rsp_ready_owner, clear rsp_valid_owner and go IDLE.
  - The non-owner port's rsp_* are unchanged.
- Latency:
  - Handshake in cycle T -> rsp_valid high from cycle T+1+EXEC_CYCLES.
  - Minimum back-to-back issue interval is EXEC_CYCLES+2 cycles, when rsp_ready is held high.
- No acceptance while RESP is pending: a new request is never accepted until the previous response is consumed (single outstanding transaction).
- The ALU drive registers keep their last values in IDLE; they are not cleared.
- Opcodes are not decoded; unused codes (0011, 1101) pass through unchanged.
- rsp_ready asserted on a port with rsp_valid low has no effect.
- A requester may drop req_valid before being granted; no state changes.
- Fairness: with both ports continuously valid, grants strictly alternate 0,1,0,1...
- busy = (state != IDLE).

Test Plan:
- Bench ALU stub: result = first_data + second_data (mod 2^32), zero = (result == 0).
- Reset, then port 0 issues op=0010, a=5, b=7, shamt=0, with rsp_ready_0=1 and EXEC_CYCLES=1:
  - req_ready_0 high in cycle T; alu_op=0010 and alu_first_data=5 in T+1.
  - rsp_valid_0 high in T+2 with result=12, zero=0; back to IDLE in T+3.
- Both ports valid from reset (port 0 a=1,b=1; port 1 a=2,b=2):
  - Port 0 granted first (result 2), then port 1 (result 4).
  - Hold both valid for 4 more requests -> grant order 0,1,0,1.
- Port 1 a=32'h80000000, b=32'h80000000:
  - result=0, zero=1.
  - Hold rsp_ready_1=0 for 5 cycles -> rsp_valid_1 and the result stay stable.
  - req_valid_0 asserted meanwhile stays unaccepted (req_ready_0=0) until rsp_ready_1 is asserted.
- EXEC_CYCLES=3, a=32'h7FFFFFFF, b=1:
  - alu_* stable for 3 cycles.
  - rsp_valid at T+4 with result=32'h80000000.
- Assert reset while in EXEC:
  - Next cycle state=IDLE, busy=0, all rsp_valid=0, alu_op=0.
  - No response appears afterwards.
- Port 0 issues op=1101 (unused code):
  - alu_op=1101 driven unchanged.
  - Response returned normally.
